controller_mc: RTL and testbench

CONTROLLER_MC -- requirements
Module: controller_mc

---
 rtl/controller_mc_pkg.sv | 36 +++
 rtl/controller_mc_if.sv | 36 +++
 rtl/wait_timer.sv | 34 +++
 rtl/controller_mc.sv | 138 +++++++++++++
 tb/tb_controller_mc.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/controller_mc_pkg.sv
// rtl/controller_mc_pkg.sv - shared state/opcode encodings for the multi-cycle controller
//
// Purpose : FSM state enum (4-bit, including HALT), opcode encodings and a
//           small decode helper used by controller_mc.
// Ports   : none (package).
package controller_mc_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_OP_ADDR    = 4'd3,
    ST_OP_FETCH   = 4'd4,
    ST_ALU_OP     = 4'd5,
    ST_STORE      = 4'd6,
    ST_NEXT       = 4'd7,
    ST_HALT       = 4'd8
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Opcodes that read a memory operand and load it (or an ALU result) into AC.
  function automatic logic loads_ac(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/controller_mc_if.sv
// rtl/controller_mc_if.sv - handshake/control bundle between controller_mc and the datapath
//
// Purpose : groups the controller inputs (opcode, zero, mem_ready, resume)
//           and all decoded control outputs.
// Modports: master - datapath/memory side, drives inputs, observes controls.
//           slave  - controller side, consumes inputs, drives controls.
interface controller_mc_if #(
  parameter int OPCODE_W = 3,
  parameter int INC_W    = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                resume;
  logic                sel;
  logic                rd;
  logic                ld_ir;
  logic                ld_ac;
  logic                ld_pc;
  logic                wr;
  logic                data_e;
  logic                halt;
  logic [INC_W-1:0]    inc_pc;
  logic [3:0]          state;
  logic                bus_err;

  modport master (
    output opcode, zero, mem_ready, resume,
    input  sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e, halt, inc_pc, state, bus_err
  );

  modport slave (
    input  opcode, zero, mem_ready, resume,
    output sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e, halt, inc_pc, state, bus_err
  );
endinterface

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - consecutive memory-wait cycle counter with timeout compare
//
// Purpose : counts cycles in which the controller holds a memory state and
//           flags when the count has reached WAIT_MAX.
// Ports   : clk, rst (async, active-high); hold - current cycle is a held
//           wait; clear - the FSM changes state this cycle; at_max - count
//           equals WAIT_MAX.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic clear,
  output logic at_max
);
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] count_q;

  assign at_max = (count_q == CNT_W'(WAIT_MAX));

  // Saturates at WAIT_MAX; the controller leaves the state on that cycle
  // anyway, and clear takes precedence when it does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (hold && !at_max) begin
      count_q <= count_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/controller_mc.sv
// rtl/controller_mc.sv - multi-cycle CPU controller with memory wait states, HALT and bus timeout
//
// Purpose : 8-state instruction sequencer plus HALT; memory states hold while
//           mem_ready=0 and time out to HALT with a sticky bus_err.
// Ports   : clk, rst (async, active-high); bus (controller_mc_if.slave):
//           opcode/zero/mem_ready/resume in; sel, rd, ld_ir, ld_ac, ld_pc,
//           wr, data_e, halt, inc_pc, state, bus_err out.
module controller_mc
  import controller_mc_pkg::*;
#(
  parameter int OPCODE_W  = 3,
  parameter int INC_W     = 2,
  parameter int SKIP_STEP = 2,
  parameter int WAIT_MAX  = 15
) (
  input logic            clk,
  input logic            rst,
  controller_mc_if.slave bus
);

  state_t      state_q, state_d;
  logic        skip_q, bus_err_q;
  logic        hold, at_max, timeout;
  logic [31:0] op_ext;
  logic        op_valid;
  logic [2:0]  op;
  logic        is_hlt, is_skz, is_sto, is_jmp, uses_mem;

  // Opcodes at or above 8 (only possible when OPCODE_W > 3) decode to nothing.
  assign op_ext   = 32'(bus.opcode);
  assign op_valid = (op_ext < 32'd8);
  assign op       = op_ext[2:0];
  assign is_hlt   = op_valid && (op == OP_HLT);
  assign is_skz   = op_valid && (op == OP_SKZ);
  assign is_sto   = op_valid && (op == OP_STO);
  assign is_jmp   = op_valid && (op == OP_JMP);
  assign uses_mem = op_valid && loads_ac(op);

  assign timeout = hold && at_max;

  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .clear  (state_d != state_q),
    .at_max (at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INST_ADDR;
      skip_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ALU_OP) begin
        skip_q <= is_skz && bus.zero;
      end else if (state_q == ST_NEXT) begin
        skip_q <= 1'b0;
      end
      if (timeout) begin
        bus_err_q <= 1'b1;
      end else if ((state_q == ST_HALT) && bus.resume) begin
        bus_err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold        = 1'b0;
    bus.sel     = 1'b0;
    bus.rd      = 1'b0;
    bus.ld_ir   = 1'b0;
    bus.ld_ac   = 1'b0;
    bus.ld_pc   = 1'b0;
    bus.wr      = 1'b0;
    bus.data_e  = 1'b0;
    bus.halt    = 1'b0;
    bus.inc_pc  = '0;
    case (state_q)
      ST_INST_ADDR: begin
        bus.sel = 1'b1;
        state_d = ST_INST_FETCH;
      end
      ST_INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
        if (bus.mem_ready) state_d = ST_INST_LOAD;
        else               hold    = 1'b1;
      end
      ST_INST_LOAD: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
        state_d   = ST_OP_ADDR;
      end
      ST_OP_ADDR: begin
        state_d = ST_OP_FETCH;
      end
      ST_OP_FETCH: begin
        bus.rd = uses_mem;
        if (bus.mem_ready) state_d = ST_ALU_OP;
        else               hold    = 1'b1;
      end
      ST_ALU_OP: begin
        bus.ld_pc  = is_jmp;
        bus.data_e = is_sto;
        state_d    = is_hlt ? ST_HALT : ST_STORE;
      end
      ST_STORE: begin
        bus.ld_ac  = uses_mem;
        bus.wr     = is_sto;
        bus.data_e = is_sto;
        // Only a store actually waits on memory here.
        if (is_sto && !bus.mem_ready) hold    = 1'b1;
        else                          state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (skip_q)      bus.inc_pc = INC_W'(SKIP_STEP);
        else if (is_jmp) bus.inc_pc = '0;
        else             bus.inc_pc = INC_W'(1);
        state_d = ST_INST_ADDR;
      end
      ST_HALT: begin
        bus.halt = 1'b1;
        // After a timeout, retry the fetch; after HLT, step past it.
        if (bus.resume) state_d = bus_err_q ? ST_INST_ADDR : ST_NEXT;
      end
      default: state_d = ST_INST_ADDR;
    endcase
    if (hold && at_max) state_d = ST_HALT;
  end

  assign bus.state   = state_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_controller_mc.sv
// tb/tb_controller_mc.sv - self-checking bench for controller_mc
module tb_controller_mc;

  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  controller_mc_if #(.OPCODE_W(3), .INC_W(2)) bus ();

  controller_mc #(
    .OPCODE_W (3),
    .INC_W    (2),
    .SKIP_STEP(2),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int obs_inc, obs_ld_pc, obs_ld_ac, obs_wr, obs_rd_of;

  typedef struct {
    int   op;
    bit   z;
    int   inc;
    int   ld_pc;
    int   ld_ac;
    int   wr;
    int   rd_of;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected control word: {sel,rd,ld_ir,ld_ac,ld_pc,wr,data_e,halt,inc_pc[1:0],bus_err}
  function automatic logic [10:0] model_outs(input int st, input int op, input bit skip, input bit berr);
    bit         reads_operand = (op >= 2) && (op <= 5);
    bit         sto = (op == 6);
    bit         jmp = (op == 7);
    logic       sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e, halt;
    logic [1:0] inc;
    sel    = (st <= 2);
    rd     = (st == 1) || (st == 2) || ((st == 4) && reads_operand);
    ld_ir  = (st == 2);
    ld_ac  = (st == 6) && reads_operand;
    ld_pc  = (st == 5) && jmp;
    wr     = (st == 6) && sto;
    data_e = ((st == 5) || (st == 6)) && sto;
    halt   = (st == 8);
    inc    = 2'd0;
    if (st == 7) inc = skip ? 2'd2 : (jmp ? 2'd0 : 2'd1);
    return {sel, rd, ld_ir, ld_ac, ld_pc, wr, data_e, halt, inc, berr};
  endfunction

  function automatic logic [10:0] dut_outs();
    return {bus.sel, bus.rd, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e,
            bus.halt, bus.inc_pc, bus.bus_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one non-HLT instruction starting in INST_ADDR. The expected state
  // trace is built from the instruction's rules: each memory state lasts
  // (waits + 1) cycles, everything else one cycle.
  task automatic run_instr(input int op, input bit z, input int w_if, input int w_of, input int w_st);
    int sq[$];
    bit mq[$];
    bit skip;
    skip = (op == 1) && z;
    sq.push_back(0); mq.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k <= w_if; k++) begin sq.push_back(1); mq.push_back(k == w_if); end
    sq.push_back(2); mq.push_back(1'($urandom_range(0, 1)));
    sq.push_back(3); mq.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k <= w_of; k++) begin sq.push_back(4); mq.push_back(k == w_of); end
    sq.push_back(5); mq.push_back(1'($urandom_range(0, 1)));
    if (op == 6) begin
      for (int k = 0; k <= w_st; k++) begin sq.push_back(6); mq.push_back(k == w_st); end
    end else begin
      sq.push_back(6); mq.push_back(1'($urandom_range(0, 1)));
    end
    sq.push_back(7); mq.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < sq.size(); i++) begin
      bus.opcode    = 3'(op);
      bus.zero      = z;
      bus.mem_ready = mq[i];
      bus.resume    = 1'($urandom_range(0, 1));
      #1;
      chk("instr_state", int'(bus.state), sq[i]);
      chk("instr_outs", int'(dut_outs()), int'(model_outs(sq[i], op, skip, 1'b0)));
      if (sq[i] == 4) obs_rd_of = int'(bus.rd);
      if (sq[i] == 5) obs_ld_pc = int'(bus.ld_pc);
      if (sq[i] == 6) begin obs_ld_ac = int'(bus.ld_ac); obs_wr = int'(bus.wr); end
      if (sq[i] == 7) obs_inc = int'(bus.inc_pc);
      step();
    end
    bus.resume = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 300000", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    tbl[0] = '{op: 2, z: 0, inc: 1, ld_pc: 0, ld_ac: 1, wr: 0, rd_of: 1};
    tbl[1] = '{op: 3, z: 1, inc: 1, ld_pc: 0, ld_ac: 1, wr: 0, rd_of: 1};
    tbl[2] = '{op: 4, z: 0, inc: 1, ld_pc: 0, ld_ac: 1, wr: 0, rd_of: 1};
    tbl[3] = '{op: 5, z: 1, inc: 1, ld_pc: 0, ld_ac: 1, wr: 0, rd_of: 1};
    tbl[4] = '{op: 6, z: 0, inc: 1, ld_pc: 0, ld_ac: 0, wr: 1, rd_of: 0};
    tbl[5] = '{op: 1, z: 1, inc: 2, ld_pc: 0, ld_ac: 0, wr: 0, rd_of: 0};
    tbl[6] = '{op: 1, z: 0, inc: 1, ld_pc: 0, ld_ac: 0, wr: 0, rd_of: 0};
    tbl[7] = '{op: 7, z: 1, inc: 0, ld_pc: 1, ld_ac: 0, wr: 0, rd_of: 0};

    bus.opcode    = 3'd2;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    bus.resume    = 1'b1;

    // Reset held across clock edges: INST_ADDR decode, resume ignored.
    #2;
    chk("reset_state", int'(bus.state), 0);
    chk("reset_outs", int'(dut_outs()), int'(model_outs(0, 2, 1'b0, 1'b0)));
    step(); step();
    chk("reset_hold_state", int'(bus.state), 0);
    rst        = 1'b0;
    bus.resume = 1'b0;

    // Table: one instruction per opcode with mem_ready always granted.
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].z, 0, 0, 0);
      chk("tbl_inc_next", obs_inc, tbl[i].inc);
      chk("tbl_ld_pc_alu", obs_ld_pc, tbl[i].ld_pc);
      chk("tbl_ld_ac_store", obs_ld_ac, tbl[i].ld_ac);
      chk("tbl_wr_store", obs_wr, tbl[i].wr);
      chk("tbl_rd_opfetch", obs_rd_of, tbl[i].rd_of);
    end

    // ADD with three wait cycles in OP_FETCH, then a STO with store waits.
    run_instr(2, 1'b0, 0, 3, 0);
    chk("opwait_bus_err", int'(bus.bus_err), 0);
    run_instr(6, 1'b0, 1, 0, 4);

    // Memory never answers in INST_FETCH: timeout into HALT.
    bus.opcode = 3'd2; bus.mem_ready = 1'b1; bus.resume = 1'b0;
    #1;
    chk("to_start_state", int'(bus.state), 0);
    step();
    bus.mem_ready = 1'b0;
    cnt = 0;
    while ((bus.state == 4'd1) && (cnt < 40)) begin
      cnt++;
      step();
    end
    chk("to_wait_cycles", cnt, WAIT_MAX + 1);
    chk("to_state_halt", int'(bus.state), 8);
    chk("to_outs", int'(dut_outs()), int'(model_outs(8, 2, 1'b0, 1'b1)));
    bus.mem_ready = 1'b1;
    step(); step();
    chk("to_halt_held", int'(bus.state), 8);
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    #1;
    chk("to_resume_state", int'(bus.state), 0);
    chk("to_resume_outs", int'(dut_outs()), int'(model_outs(0, 2, 1'b0, 1'b0)));

    // HLT: halt held for 10 cycles, then resume steps past it via NEXT.
    bus.opcode = 3'd0; bus.mem_ready = 1'b1;
    for (int st = 0; st <= 5; st++) begin
      #1;
      chk("hlt_state", int'(bus.state), st);
      chk("hlt_outs", int'(dut_outs()), int'(model_outs(st, 0, 1'b0, 1'b0)));
      step();
    end
    for (int c = 0; c < 10; c++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("hlt_halt_state", int'(bus.state), 8);
      chk("hlt_halt_outs", int'(dut_outs()), int'(model_outs(8, 0, 1'b0, 1'b0)));
      step();
    end
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    #1;
    chk("hlt_resume_state", int'(bus.state), 7);
    chk("hlt_resume_inc", int'(bus.inc_pc), 1);
    step();
    chk("hlt_after_next", int'(bus.state), 0);

    // Asynchronous reset in the middle of an OP_FETCH wait.
    bus.opcode = 3'd2; bus.mem_ready = 1'b1;
    step(); step(); step(); step();
    chk("arst_pre_state", int'(bus.state), 4);
    bus.mem_ready = 1'b0;
    step(); step();
    chk("arst_wait_state", int'(bus.state), 4);
    chk("arst_wait_rd", int'(bus.rd), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_outs", int'(dut_outs()), int'(model_outs(0, 2, 1'b0, 1'b0)));
    step();
    chk("arst_held_state", int'(bus.state), 0);
    rst = 1'b0;
    bus.mem_ready = 1'b1;

    // Random instruction stream with random wait patterns and stray resume.
    for (int n = 0; n < 30; n++) begin
      run_instr($urandom_range(1, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
